// File: rtl/if_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package if_fetch_pkg;

    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_WAIT = 2'd1,
        IF_HOLD = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface if_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [INST_W-1:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/if_watchdog.sv
// Wait-cycle counter for an outstanding fetch; flags expiry on the MAX_WAIT-th unacked cycle.
module if_watchdog #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_tick,
    output logic o_expire
);
    localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_cnt <= '0;
        else if (i_start) r_cnt <= '0;
        else if (i_tick)  r_cnt <= r_cnt + 8'd1;
    end

    assign o_expire = i_tick && (r_cnt == LIMIT);
endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: one memory request per PC, kill on redirect, hold under IF/ID stall.
// Optional macro IF_FETCH_TIMEOUT_EN adds a watchdog and sticky timeout_o output.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          INST_W   = 32,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic [5:0]        stall,
    input  logic              flush_i,
    if_fetch_if.master        mem,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              if_valid_o,
    output logic              stallreq_o
`ifdef IF_FETCH_TIMEOUT_EN
    ,
    output logic              timeout_o
`endif
);
    if_state_e         r_state;
    logic              r_kill;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_if_pc;
    logic [INST_W-1:0] r_if_inst;
    logic              r_valid;
    logic [ADDR_W-1:0] r_buf_pc;
    logic [INST_W-1:0] r_buf_inst;
    logic              w_expire;
    logic              w_unused;

    assign mem.mem_req  = r_req;
    assign mem.mem_addr = r_addr;
    assign if_pc_o      = r_if_pc;
    assign if_inst_o    = r_if_inst;
    assign if_valid_o   = r_valid;

    // Drops in the ack cycle so the PC register advances on that same edge.
    assign stallreq_o = ((r_state == IF_WAIT) && !mem.mem_ack) || (r_state == IF_HOLD);

`ifdef IF_FETCH_TIMEOUT_EN
    logic w_start;
    logic w_tick;
    logic r_timeout;

    assign w_start = (r_state == IF_IDLE) && ce_i && !flush_i;
    assign w_tick  = (r_state == IF_WAIT) && !mem.mem_ack;

    if_watchdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_tick   (w_tick),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_timeout <= 1'b0;
        else if (w_expire) r_timeout <= 1'b1;
    end

    assign timeout_o = r_timeout;
    assign w_unused  = ^{stall[5:2], stall[STALL_PC]};
`else
    assign w_expire = 1'b0;
    assign w_unused = ^{stall[5:2], stall[STALL_PC], (MAX_WAIT != 0)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IF_IDLE;
            r_kill     <= 1'b0;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_if_pc    <= '0;
            r_if_inst  <= INST_W'(NOP_INST);
            r_valid    <= 1'b0;
            r_buf_pc   <= '0;
            r_buf_inst <= INST_W'(ZERO_WORD);
        end else begin
            // Delivery is a single-cycle pulse; NOP whenever nothing is delivered.
            r_valid   <= 1'b0;
            r_if_inst <= INST_W'(NOP_INST);
            case (r_state)
                IF_IDLE: begin
                    if (ce_i && !flush_i) begin
                        r_req   <= 1'b1;
                        r_addr  <= pc_i;
                        r_state <= IF_WAIT;
                    end else begin
                        r_req <= 1'b0;
                    end
                end
                IF_WAIT: begin
                    if (w_expire) begin
                        r_req   <= 1'b0;
                        r_kill  <= 1'b0;
                        r_state <= IF_IDLE;
                    end else if (mem.mem_ack) begin
                        r_req <= 1'b0;
                        if (r_kill || flush_i) begin
                            r_kill  <= 1'b0;
                            r_state <= IF_IDLE;
                        end else if (!stall[STALL_IF]) begin
                            r_if_pc   <= r_addr;
                            r_if_inst <= mem.mem_rdata;
                            r_valid   <= 1'b1;
                            r_state   <= IF_IDLE;
                        end else begin
                            r_buf_pc   <= r_addr;
                            r_buf_inst <= mem.mem_rdata;
                            r_state    <= IF_HOLD;
                        end
                    end else if (flush_i) begin
                        // Request stays on the bus; the response is dropped when it lands.
                        r_kill <= 1'b1;
                    end
                end
                IF_HOLD: begin
                    if (flush_i) begin
                        r_state <= IF_IDLE;
                    end else if (!stall[STALL_IF]) begin
                        r_if_pc   <= r_buf_pc;
                        r_if_inst <= r_buf_inst;
                        r_valid   <= 1'b1;
                        r_state   <= IF_IDLE;
                    end
                end
                default: r_state <= IF_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a transaction-level reference model checked every cycle.
module tb_if_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          MW  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = '0;
    logic        ce_i = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush_i = 1'b0;
    logic [31:0] if_pc_o, if_inst_o;
    logic        if_valid_o, stallreq_o;
`ifdef IF_FETCH_TIMEOUT_EN
    logic        timeout_o;
`endif

    if_fetch_if #(.ADDR_W(32), .INST_W(32)) mem_bus ();

    if_fetch #(.ADDR_W(32), .INST_W(32), .MAX_WAIT(MW)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .ce_i       (ce_i),
        .stall      (stall),
        .flush_i    (flush_i),
        .mem        (mem_bus),
        .if_pc_o    (if_pc_o),
        .if_inst_o  (if_inst_o),
        .if_valid_o (if_valid_o),
        .stallreq_o (stallreq_o)
`ifdef IF_FETCH_TIMEOUT_EN
        ,
        .timeout_o  (timeout_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit done  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding fetch (busy/killed), one held response, delivery record.
    bit          m_busy, m_killed, m_held, m_valid, m_to, m_dlv;
    logic [31:0] m_addr, m_hpc, m_hinst, m_pc, m_inst, m_dpc, m_dinst;
    int          m_wait;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_killed = 0; m_held = 0; m_valid = 0; m_to = 0;
            m_addr = '0; m_hpc = '0; m_hinst = '0; m_pc = '0; m_inst = NOP; m_wait = 0;
        end else begin
            m_dlv = 0; m_dpc = '0; m_dinst = '0;
            if (m_held) begin
                if (flush_i) m_held = 0;
                else if (!stall[1]) begin m_dlv = 1; m_dpc = m_hpc; m_dinst = m_hinst; m_held = 0; end
            end else if (m_busy) begin
                if (!mem_bus.mem_ack) begin
                    m_wait++;
`ifdef IF_FETCH_TIMEOUT_EN
                    if (m_wait == MW) begin m_busy = 0; m_killed = 0; m_to = 1; end
`endif
                    if (m_busy && flush_i) m_killed = 1;
                end else begin
                    m_busy = 0;
                    if (m_killed || flush_i) m_killed = 0;
                    else if (!stall[1]) begin m_dlv = 1; m_dpc = m_addr; m_dinst = mem_bus.mem_rdata; end
                    else begin m_held = 1; m_hpc = m_addr; m_hinst = mem_bus.mem_rdata; end
                end
            end else if (ce_i && !flush_i) begin
                m_busy = 1; m_addr = pc_i; m_wait = 0;
            end
            m_valid = m_dlv;
            m_inst  = m_dlv ? m_dinst : NOP;
            if (m_dlv) m_pc = m_dpc;
        end
    end

    always @(negedge clk) begin
        if (!rst && !done) begin
            chk("cyc.mem_req", {31'b0, mem_bus.mem_req}, {31'b0, m_busy});
            chk("cyc.mem_addr", mem_bus.mem_addr, m_addr);
            chk("cyc.stallreq", {31'b0, stallreq_o}, {31'b0, (m_busy && !mem_bus.mem_ack) || m_held});
            chk("cyc.valid", {31'b0, if_valid_o}, {31'b0, m_valid});
            chk("cyc.if_pc", if_pc_o, m_pc);
            chk("cyc.if_inst", if_inst_o, m_inst);
`ifdef IF_FETCH_TIMEOUT_EN
            chk("cyc.timeout", {31'b0, timeout_o}, {31'b0, m_to});
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a fetch at pc; on return the DUT is in its first WAIT cycle with ce_i low.
    task automatic issue(input logic [31:0] pc);
        pc_i = pc; ce_i = 1'b1;
        step();
        ce_i = 1'b0;
    endtask

    initial begin
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = '0;
        #12;
        chk("rst.req", {31'b0, mem_bus.mem_req}, 32'd0);
        chk("rst.addr", mem_bus.mem_addr, 32'd0);
        chk("rst.if_pc", if_pc_o, 32'd0);
        chk("rst.inst", if_inst_o, NOP);
        chk("rst.valid", {31'b0, if_valid_o}, 32'd0);
        step();
        rst = 1'b0;

        // 1-cycle memory at pc 0
        issue(32'h0);
        chk("t1.req", {31'b0, mem_bus.mem_req}, 32'd1);
        chk("t1.stallreq_wait", {31'b0, stallreq_o}, 32'd1);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0050_0093;
        #1 chk("t1.stallreq_ack", {31'b0, stallreq_o}, 32'd0);
        step();
        mem_bus.mem_ack = 1'b0;
        chk("t1.valid", {31'b0, if_valid_o}, 32'd1);
        chk("t1.pc", if_pc_o, 32'h0);
        chk("t1.inst", if_inst_o, 32'h0050_0093);
        chk("t1.req_drop", {31'b0, mem_bus.mem_req}, 32'd0);
        step();
        chk("t1.pulse_end", {31'b0, if_valid_o}, 32'd0);
        chk("t1.nop", if_inst_o, NOP);

        // 3-cycle memory at pc 4
        issue(32'h4);
        step();
        chk("t2.addr_c2", mem_bus.mem_addr, 32'h4);
        chk("t2.stall_c2", {31'b0, stallreq_o}, 32'd1);
        step();
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0040_8193;
        chk("t2.addr_c3", mem_bus.mem_addr, 32'h4);
        step();
        mem_bus.mem_ack = 1'b0;
        chk("t2.valid", {31'b0, if_valid_o}, 32'd1);
        chk("t2.pc", if_pc_o, 32'h4);
        step();

        // Redirect in 2nd WAIT cycle; ack two cycles later is discarded
        issue(32'h8);
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        step();
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hBAD0_0001;
        step();
        mem_bus.mem_ack = 1'b0;
        chk("t3.no_valid", {31'b0, if_valid_o}, 32'd0);
        chk("t3.nop", if_inst_o, NOP);
        chk("t3.pc_kept", if_pc_o, 32'h4);
        issue(32'h100);
        chk("t3.redir_addr", mem_bus.mem_addr, 32'h100);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0000_0073;
        step();
        mem_bus.mem_ack = 1'b0;
        chk("t3.redir_valid", {31'b0, if_valid_o}, 32'd1);
        chk("t3.redir_inst", if_inst_o, 32'h0000_0073);
        step();

        // Flush coincident with ack
        issue(32'h104);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hDEAD_BEEF; flush_i = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0; flush_i = 1'b0;
        chk("t4.no_valid", {31'b0, if_valid_o}, 32'd0);
        chk("t4.nop", if_inst_o, NOP);
        step();

        // IF/ID stall during ack, released 3 cycles later
        issue(32'h108);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h00A0_0113; stall = 6'b000011;
        step();
        mem_bus.mem_ack = 1'b0;
        chk("t5.hold_stallreq", {31'b0, stallreq_o}, 32'd1);
        step();
        chk("t5.hold_novalid", {31'b0, if_valid_o}, 32'd0);
        step();
        stall = 6'b000000;
        chk("t5.release_stallreq", {31'b0, stallreq_o}, 32'd1);
        step();
        chk("t5.valid", {31'b0, if_valid_o}, 32'd1);
        chk("t5.pc", if_pc_o, 32'h108);
        chk("t5.inst", if_inst_o, 32'h00A0_0113);
        step();

        // Flush beats release in HOLD
        issue(32'h10C);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1111_2222; stall = 6'b000010;
        step();
        mem_bus.mem_ack = 1'b0; stall = 6'b000000; flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("t6.no_valid", {31'b0, if_valid_o}, 32'd0);
        chk("t6.stallreq", {31'b0, stallreq_o}, 32'd0);

        // No fetch while flush is asserted in IDLE
        pc_i = 32'h200; ce_i = 1'b1; flush_i = 1'b1;
        step();
        chk("t7.no_req", {31'b0, mem_bus.mem_req}, 32'd0);
        ce_i = 1'b0; flush_i = 1'b0;
        step();

`ifdef IF_FETCH_TIMEOUT_EN
        // Memory never acks
        issue(32'h300);
        step(); step();
        step();
        chk("t8.before_to", {31'b0, timeout_o}, 32'd0);
        step();
        chk("t8.timeout", {31'b0, timeout_o}, 32'd1);
        chk("t8.req_drop", {31'b0, mem_bus.mem_req}, 32'd0);
        chk("t8.stallreq", {31'b0, stallreq_o}, 32'd0);
        #2 rst = 1'b1;
        #1 chk("t8.async_clr", {31'b0, timeout_o}, 32'd0);
        rst = 1'b0;
        step();
`endif

        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
